// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Shared types and helpers for the rq/gnt/start/rdy bus memory
//               responder: command mode encoding, responder state encoding
//               and mode-decoding helper functions.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

  // Command mode as sampled with start.
  typedef enum logic [1:0] {
    MODE_RD  = 2'b00,
    MODE_WR  = 2'b01,
    MODE_BRD = 2'b10,
    MODE_BWR = 2'b11
  } mode_e;

  // Responder state.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANTED = 3'd1,
    WR      = 3'd2,
    RD_WAIT = 3'd3,
    RD      = 3'd4
  } state_e;

  function automatic logic is_write(mode_e m);
    return (m == MODE_WR) || (m == MODE_BWR);
  endfunction

  function automatic logic is_burst(mode_e m);
    return (m == MODE_BRD) || (m == MODE_BWR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : bus_mem_array
// Description : Single-port synchronous word array with a 1-cycle registered
//               read. The read register returns to zero in any cycle that
//               follows no read, so it can feed a bus data output directly.
//               Array contents are never reset; only the read register is.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset (read register only)
//               we     - write enable, wdata -> array[addr]
//               re     - read enable, array[addr] -> rdata next cycle
//               addr   - word address
//               wdata  - write data
//               rdata  - registered read data (0 when no read was issued)
// Revision    : 1.0 - initial release
// ============================================================================
module bus_mem_array #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] r_mem [2**AWIDTH];
  logic [DWIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (re) begin
      r_rdata <= r_mem[addr];
    end else begin
      r_rdata <= '0;
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/bus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : bus_mem_responder
// Description : Memory-side responder for the rq/gnt/start/rdy bus. Grants
//               the bus on request, accepts single and burst read/write
//               commands and services them from an internal word array with
//               a fixed read latency of RD_LAT cycles from start to the first
//               read beat. All outputs are registered.
// Ports       : clk     - bus clock, rising edge
//               rst_n   - asynchronous active-low reset
//               rq      - initiator bus request (level)
//               start   - command strobe, honoured only in GRANTED
//               mode    - 00 read, 01 write, 10 burst read, 11 burst write
//               addr    - command start address
//               data_i  - write data from bus
//               gnt     - bus granted
//               rdy     - data beat valid/accepted this cycle
//               data_o  - read data (0 outside read beats)
//               data_oe - drive enable for data_o
// Revision    : 1.0 - initial release
// ============================================================================
module bus_mem_responder
  import bus_pkg::*;
#(
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 8,
  parameter int RD_LAT    = 2,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rq,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] data_i,
  output logic              gnt,
  output logic              rdy,
  output logic [DWIDTH-1:0] data_o,
  output logic              data_oe
);

  localparam int              c_bw        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [c_bw-1:0] c_last_beat = c_bw'(BURST_LEN - 1);
  localparam logic [2:0]      c_lat_load  = 3'(RD_LAT - 1);

  // Registered state
  state_e            r_state;
  logic              r_gnt;
  logic              r_rdy;
  logic              r_oe;
  mode_e             r_mode;
  logic [AWIDTH-1:0] r_addr;   // captured start address, held for the whole command
  logic [c_bw-1:0]   r_beat;   // index k of the beat currently on the bus
  logic [2:0]        r_lat;    // remaining read latency while in RD_WAIT

  // Next-state values
  state_e            w_state_nxt;
  logic              w_gnt_nxt;
  logic              w_rdy_nxt;
  logic              w_oe_nxt;
  mode_e             w_mode_nxt;
  logic [AWIDTH-1:0] w_addr_nxt;
  logic [c_bw-1:0]   w_beat_nxt;
  logic [2:0]        w_lat_nxt;

  // Array control
  logic              w_ram_we;
  logic              w_ram_re;
  logic [AWIDTH-1:0] w_ram_addr;

  mode_e             w_start_mode;
  logic              w_last;
  logic [c_bw-1:0]   w_beat_inc;

  assign w_start_mode = mode_e'(mode);
  assign w_last       = is_burst(r_mode) ? (r_beat == c_last_beat) : 1'b1;
  assign w_beat_inc   = r_beat + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= 1'b0;
      r_rdy   <= 1'b0;
      r_oe    <= 1'b0;
      r_mode  <= MODE_RD;
      r_addr  <= '0;
      r_beat  <= '0;
      r_lat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_rdy   <= w_rdy_nxt;
      r_oe    <= w_oe_nxt;
      r_mode  <= w_mode_nxt;
      r_addr  <= w_addr_nxt;
      r_beat  <= w_beat_nxt;
      r_lat   <= w_lat_nxt;
    end
  end

  // rdy/data_oe are next-state values so they line up with the cycle the
  // corresponding beat (or array read result) is on the bus. A read is
  // issued to the array one cycle ahead of the beat it produces.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_rdy_nxt   = 1'b0;
    w_oe_nxt    = 1'b0;
    w_mode_nxt  = r_mode;
    w_addr_nxt  = r_addr;
    w_beat_nxt  = r_beat;
    w_lat_nxt   = r_lat;
    w_ram_we    = 1'b0;
    w_ram_re    = 1'b0;
    w_ram_addr  = r_addr + AWIDTH'(r_beat);

    case (r_state)
      IDLE: begin
        if (rq) begin
          w_state_nxt = GRANTED;
          w_gnt_nxt   = 1'b1;
        end
      end

      GRANTED: begin
        // start takes priority over a simultaneous rq release
        if (start) begin
          w_mode_nxt = w_start_mode;
          w_addr_nxt = addr;
          w_beat_nxt = '0;
          if (is_write(w_start_mode)) begin
            w_state_nxt = WR;
            w_rdy_nxt   = 1'b1;
          end else if (RD_LAT == 1) begin
            // No wait cycles: read the array straight from the command address
            w_state_nxt = RD;
            w_ram_re    = 1'b1;
            w_ram_addr  = addr;
            w_rdy_nxt   = 1'b1;
            w_oe_nxt    = 1'b1;
          end else begin
            w_state_nxt = RD_WAIT;
            w_lat_nxt   = c_lat_load;
          end
        end else if (!rq) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = 1'b0;
        end
      end

      WR: begin
        w_ram_we = 1'b1;
        if (w_last) begin
          w_state_nxt = rq ? GRANTED : IDLE;
          w_gnt_nxt   = rq;
        end else begin
          w_beat_nxt = w_beat_inc;
          w_rdy_nxt  = 1'b1;
        end
      end

      RD_WAIT: begin
        if (r_lat == 3'd1) begin
          // Issue beat 0 (r_beat is 0 here, so the default address applies)
          w_state_nxt = RD;
          w_ram_re    = 1'b1;
          w_rdy_nxt   = 1'b1;
          w_oe_nxt    = 1'b1;
        end else begin
          w_lat_nxt = r_lat - 3'd1;
        end
      end

      RD: begin
        if (w_last) begin
          w_state_nxt = rq ? GRANTED : IDLE;
          w_gnt_nxt   = rq;
        end else begin
          w_beat_nxt = w_beat_inc;
          w_ram_re   = 1'b1;
          w_ram_addr = r_addr + AWIDTH'(w_beat_inc);
          w_rdy_nxt  = 1'b1;
          w_oe_nxt   = 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = 1'b0;
      end
    endcase
  end

  bus_mem_array #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_ram_we),
    .re    (w_ram_re),
    .addr  (w_ram_addr),
    .wdata (data_i),
    .rdata (data_o)
  );

  assign gnt     = r_gnt;
  assign rdy     = r_rdy;
  assign data_oe = r_oe;

endmodule
`default_nettype wire

// File: tb/tb_bus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_mem_responder
// Description : Directed self-checking bench for bus_mem_responder with
//               default parameters (8-bit data/address, RD_LAT=2,
//               BURST_LEN=4). Inputs change on the falling edge; outputs are
//               sampled on the falling edge.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_mem_responder;

  logic       clk;
  logic       rst_n;
  logic       rq;
  logic       start;
  logic [1:0] mode;
  logic [7:0] addr;
  logic [7:0] data_i;
  logic       gnt;
  logic       rdy;
  logic [7:0] data_o;
  logic       data_oe;

  int checks;
  int errors;
  logic [7:0] bvals [4];

  bus_mem_responder #(
    .DWIDTH    (8),
    .AWIDTH    (8),
    .RD_LAT    (2),
    .BURST_LEN (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rq      (rq),
    .start   (start),
    .mode    (mode),
    .addr    (addr),
    .data_i  (data_i),
    .gnt     (gnt),
    .rdy     (rdy),
    .data_o  (data_o),
    .data_oe (data_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Waits (bounded) for gnt; returns at a falling edge where gnt is high.
  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (gnt === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rq = 1'b1; start = 1'b0; mode = 2'b00; addr = 8'h00; data_i = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", rdy); end
    checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", data_oe); end
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_o); end
    rq = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL idle_gnt: got %b want 0", gnt); end
  endtask

  task automatic test_grant();
    rq = 1'b1;
    @(negedge clk);
    checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL grant_latency: got %b want 1", gnt); end
    rq = 1'b0;
    @(negedge clk);
    checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL grant_release: got %b want 0", gnt); end
  endtask

  task automatic test_single();
    bit ok;
    rq = 1'b1;
    wait_gnt(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_gnt: got %b want 1", gnt); end
    start = 1'b1; mode = 2'b01; addr = 8'h10; data_i = 8'hA5;
    @(negedge clk);
    start = 1'b0;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL sw_rdy: got %b want 1", rdy); end
    checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL sw_oe: got %b want 0", data_oe); end
    @(negedge clk);
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL sw_done_rdy: got %b want 0", rdy); end
    checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL sw_done_gnt: got %b want 1", gnt); end
    // read issued the cycle right after the write beat
    start = 1'b1; mode = 2'b00; addr = 8'h10; data_i = 8'h00;
    @(negedge clk);
    start = 1'b0;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL sr_early_rdy: got %b want 0", rdy); end
    @(negedge clk);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL sr_rdy: got %b want 1", rdy); end
    checks++; if (data_oe !== 1'b1) begin errors++; $display("FAIL sr_oe: got %b want 1", data_oe); end
    checks++; if (data_o !== 8'hA5) begin errors++; $display("FAIL sr_data: got %h want a5", data_o); end
    @(negedge clk);
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL sr_end_rdy: got %b want 0", rdy); end
    checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL sr_end_oe: got %b want 0", data_oe); end
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL sr_end_data: got %h want 00", data_o); end
  endtask

  // Burst write at 0xFE with a stray start during the transfer.
  task automatic test_burst_write();
    start = 1'b1; mode = 2'b11; addr = 8'hFE;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL bw_rdy%0d: got %b want 1", k, rdy); end
      data_i = bvals[k];
      if (k == 1) begin start = 1'b1; mode = 2'b00; addr = 8'h50; end
      if (k == 2) begin start = 1'b0; end
      @(negedge clk);
    end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL bw_end_rdy: got %b want 0", rdy); end
    checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL bw_end_gnt: got %b want 1", gnt); end
    data_i = 8'h00;
    @(negedge clk);
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL bw_extra_rdy: got %b want 0", rdy); end
  endtask

  task automatic test_burst_read();
    start = 1'b1; mode = 2'b10; addr = 8'hFE;
    @(negedge clk);
    start = 1'b0;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL br_early_rdy: got %b want 0", rdy); end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL br_rdy%0d: got %b want 1", k, rdy); end
      checks++; if (data_oe !== 1'b1) begin errors++; $display("FAIL br_oe%0d: got %b want 1", k, data_oe); end
      checks++; if (data_o !== bvals[k]) begin errors++; $display("FAIL br_data%0d: got %h want %h", k, data_o, bvals[k]); end
      @(negedge clk);
    end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL br_end_rdy: got %b want 0", rdy); end
    checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL br_end_oe: got %b want 0", data_oe); end
  endtask

  task automatic test_rq_drop();
    start = 1'b1; mode = 2'b10; addr = 8'hFE;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL rqd_rdy%0d: got %b want 1", k, rdy); end
      checks++; if (data_o !== bvals[k]) begin errors++; $display("FAIL rqd_data%0d: got %h want %h", k, data_o, bvals[k]); end
      checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL rqd_gnt%0d: got %b want 1", k, gnt); end
      if (k == 1) rq = 1'b0;
      @(negedge clk);
    end
    checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL rqd_end_gnt: got %b want 0", gnt); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL rqd_end_rdy: got %b want 0", rdy); end
    @(negedge clk);
    checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL rqd_idle_gnt: got %b want 0", gnt); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    rq = 1'b1;
    wait_gnt(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rm_gnt: got %b want 1", gnt); end
    start = 1'b1; mode = 2'b10; addr = 8'hFE;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++; if (data_o !== bvals[0]) begin errors++; $display("FAIL rm_beat0: got %h want %h", data_o, bvals[0]); end
    @(negedge clk);
    checks++; if (data_o !== bvals[1]) begin errors++; $display("FAIL rm_beat1: got %h want %h", data_o, bvals[1]); end
    rst_n = 1'b0;
    rq = 1'b0;
    #1;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL rm_async_rdy: got %b want 0", rdy); end
    checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL rm_async_oe: got %b want 0", data_oe); end
    checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL rm_async_gnt: got %b want 0", gnt); end
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL rm_async_data: got %h want 00", data_o); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL rm_post_gnt: got %b want 0", gnt); end
    rq = 1'b1;
    wait_gnt(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rm_regnt: got %b want 1", gnt); end
    start = 1'b1; mode = 2'b00; addr = 8'h01;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL rm_rd_rdy: got %b want 1", rdy); end
    checks++; if (data_o !== 8'h44) begin errors++; $display("FAIL rm_rd_data: got %h want 44", data_o); end
    @(negedge clk);
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL rm_rd_end: got %b want 0", rdy); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    bvals[0] = 8'h11;
    bvals[1] = 8'h22;
    bvals[2] = 8'h33;
    bvals[3] = 8'h44;
    test_reset();
    test_grant();
    test_single();
    test_burst_write();
    test_burst_read();
    test_rq_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_mem_responder.md
Name: bus_mem_responder

Overview:
Memory-side responder for the shared rq/gnt/start/rdy bus. It is the counterpart to the CPU initiator.
- Grants the bus to a requesting initiator.
- Accepts single and 4-beat burst read/write commands.
- Services them from an internal synchronous word array with a fixed read latency.
- The bidirectional data line is split into data_i/data_o/data_oe. The tristate driver lives in the bus wrapper.

Parameters:
DWIDTH, 8, data word width
AWIDTH, 8, address width; array depth = 2**AWIDTH words
RD_LAT, 2, cycles from start to first read beat (legal range 1..7)
BURST_LEN, 4, beats per burst command (power of 2, 2..16)

Ports:
clk  input  1  bus clock, rising edge
rst_n  input  1  asynchronous active-low reset
rq  input  1  initiator bus request, level
start  input  1  command strobe, 1 cycle, valid only while gnt=1
mode  input  2  00 read, 01 write, 10 burst read, 11 burst write; sampled with start
addr  input  AWIDTH  start address; sampled with start
data_i  input  DWIDTH  write data from bus
gnt  output  1  bus granted
rdy  output  1  data beat valid/accepted this cycle
data_o  output  DWIDTH  read data
data_oe  output  1  drive enable for data_o onto bus

Behaviour:
- Reset (async assert, sync release): state IDLE; gnt=0, rdy=0, data_o=0, data_oe=0; beat/latency counters 0. Array contents are not reset.
- All outputs are registered.
- IDLE: rq=1 -> GRANTED; gnt=1 from the next cycle.
- GRANTED:
  - rq=0 -> IDLE; gnt=0 next cycle.
  - start=1 -> capture mode/addr into working registers, then branch by mode:
    - write: -> WR.
    - read: -> RD_WAIT with latency count RD_LAT-1.
  - If rq=0 and start=1 in the same cycle, start wins.
- WR:
  - rdy=1 in cycles start+1 .. start+N, where N=1 (single) or BURST_LEN (burst).
  - data_i is written to array[addr_k] on each rising edge where rdy=1.
- RD_WAIT: counts down. Array reads are issued early so that beat k is presented in cycle start+RD_LAT+k, k=0..N-1, with rdy=1, data_oe=1 and data_o=array[addr_k].
- Beat addressing: addr_k = addr+k modulo 2**AWIDTH; 0xFF wraps to 0x00.
- data_oe=1 only in read beat cycles; data_o returns to 0 when data_oe=0.
- Completion: after the last beat, rdy/data_oe=0 next cycle. The next state is GRANTED if rq=1, else IDLE (gnt drops that cycle).
- rq deasserted mid-transfer: the transfer completes in full, and gnt stays 1 until completion.
- start while not in GRANTED (including during a transfer): ignored, with no state effect.
- Read-after-write to the same address: a read command issued the cycle after the final write beat returns the new data.
- Back-to-back commands are legal from the first GRANTED cycle after completion. Minimum command-to-command spacing = N+1 (write) or RD_LAT+N (read).
- Reset mid-transfer: outputs clear immediately. A partial burst write leaves the beats already written in the array.

Decomposition:
- Package bus_pkg holds:
  - typedef enum logic [1:0] mode_e {MODE_RD, MODE_WR, MODE_BRD, MODE_BWR};
  - responder state enum {IDLE, GRANTED, WR, RD_WAIT, RD};
  - helper functions is_write(mode_e) and is_burst(mode_e).
- One sub-module: bus_mem_array. It is a single-port synchronous RAM with 1-cycle read, a write enable, and the DWIDTH/AWIDTH parameters.

Test Plan:
- Reset then rq=1 -> gnt=1 exactly one cycle later. rq=0 in GRANTED -> gnt=0 next cycle. All outputs 0 during reset.
- Single write mode=01, addr=0x10, data_i=0xA5; then single read of 0x10 -> rdy and data_oe high at start+2 (RD_LAT=2) with data_o=0xA5, all for 1 cycle.
- Burst write mode=11, addr=0xFE, beats 0x11,0x22,0x33,0x44 -> array[0xFE]=0x11, [0xFF]=0x22, [0x00]=0x33, [0x01]=0x44. Burst read at 0xFE returns the same four values on 4 consecutive rdy cycles.
- rq dropped at the second beat of a burst read -> all 4 beats delivered, then gnt=0 the cycle after the last beat.
- start pulsed during an active burst write -> ignored: no extra beats, and addr/mode are unchanged.
- Reset asserted mid-burst-read (beat 2) -> rdy, data_oe, gnt go 0 asynchronously. After release, a new rq/start read completes normally.
